// File: rtl/serial_buff_ctrl.sv
// rtl/serial_buff_ctrl.sv - sync-word hunt and NDATA-bit capture sequencer for serial_buff
// Bit strobe generator, sync detector and frame handshake in one registered FSM.
module serial_buff_ctrl #(
  parameter int               NDATA     = 128,
  parameter int               SYNCW     = 8,
  parameter logic [SYNCW-1:0] SYNC_WORD = 8'hA5,
  parameter int               CLKDIV    = 1,
  parameter bit               CONT      = 1'b0,
  parameter int               CW        = $clog2(NDATA + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          din_i,
  output logic          buf_clr_o,
  output logic          shift_en_o,
  output logic [CW-1:0] bit_cnt_o,
  output logic          frame_valid_o,
  input  logic          frame_ready_i,
  output logic          busy_o,
  output logic [15:0]   frame_cnt_o
);

  localparam int             PW       = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [PW-1:0]  PH_LAST  = PW'(CLKDIV - 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(NDATA - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HUNT,
    S_CAPTURE,
    S_HOLD
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   phase_q;
  logic [SYNCW-1:0] sync_q;
  logic [CW-1:0]   bit_cnt_q;
  logic [15:0]     frame_cnt_q;
  logic            buf_clr_q;
  logic            frame_valid_q;
  logic            busy_q;

  logic            strobe;
  logic [PW-1:0]   phase_d;
  logic [SYNCW-1:0] sync_d;
  logic [CW-1:0]   bit_cnt_d;

  always_comb begin
    strobe    = (state_q != S_IDLE) && (phase_q == PH_LAST);
    phase_d   = strobe ? '0 : phase_q + PW'(1);
    sync_d    = {sync_q[SYNCW-2:0], din_i};
    bit_cnt_d = bit_cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      phase_q       <= '0;
      sync_q        <= '0;
      bit_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      buf_clr_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      buf_clr_q <= 1'b0;
      if (state_q != S_IDLE) begin
        phase_q <= phase_d;
      end
      // Abort wins over every transition, including a pending handshake.
      if (abort_i) begin
        state_q       <= S_IDLE;
        phase_q       <= '0;
        sync_q        <= '0;
        bit_cnt_q     <= '0;
        frame_valid_q <= 1'b0;
        busy_q        <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            sync_q    <= '0;
            bit_cnt_q <= '0;
            phase_q   <= '0;
            if (start_i) begin
              state_q   <= S_HUNT;
              buf_clr_q <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
          S_HUNT: begin
            if (strobe) begin
              sync_q <= sync_d;
              if (sync_d == SYNC_WORD) begin
                state_q <= S_CAPTURE;
              end
            end
          end
          S_CAPTURE: begin
            if (strobe) begin
              bit_cnt_q <= bit_cnt_d;
              if (bit_cnt_q == CNT_LAST) begin
                state_q       <= S_HOLD;
                frame_valid_q <= 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (frame_ready_i) begin
              frame_cnt_q   <= frame_cnt_q + 16'd1;
              frame_valid_q <= 1'b0;
              bit_cnt_q     <= '0;
              sync_q        <= '0;
              if (CONT) begin
                state_q   <= S_HUNT;
                buf_clr_q <= 1'b1;
                phase_q   <= '0;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // The buffer must shift in the same cycle the strobe samples din.
  assign shift_en_o    = (state_q == S_CAPTURE) && strobe;
  assign buf_clr_o     = buf_clr_q;
  assign bit_cnt_o     = bit_cnt_q;
  assign frame_valid_o = frame_valid_q;
  assign busy_o        = busy_q;
  assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_serial_buff_ctrl.sv
// tb/tb_serial_buff_ctrl.sv - directed self-checking bench for serial_buff_ctrl
// Instance 0: CLKDIV=1 CONT=0, instance 1: CLKDIV=1 CONT=1, instance 2: CLKDIV=4 CONT=0.
module tb_serial_buff_ctrl;

  logic        clk;
  logic        rst_n;
  logic        din;
  logic        abort;
  logic        start       [3];
  logic        frame_ready [3];
  logic        buf_clr     [3];
  logic        shift_en    [3];
  logic [7:0]  bit_cnt     [3];
  logic        frame_valid [3];
  logic        busy        [3];
  logic [15:0] frame_cnt   [3];

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          sel = 0;
  int          nshift, first_sh, last_sh, bad_gap, bad, h0;
  logic [127:0] cap;
  logic [127:0] data;

  serial_buff_ctrl #(.CLKDIV(1), .CONT(1'b0)) u_d0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .abort_i(abort), .din_i(din),
    .buf_clr_o(buf_clr[0]), .shift_en_o(shift_en[0]), .bit_cnt_o(bit_cnt[0]),
    .frame_valid_o(frame_valid[0]), .frame_ready_i(frame_ready[0]),
    .busy_o(busy[0]), .frame_cnt_o(frame_cnt[0]));

  serial_buff_ctrl #(.CLKDIV(1), .CONT(1'b1)) u_d1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .abort_i(abort), .din_i(din),
    .buf_clr_o(buf_clr[1]), .shift_en_o(shift_en[1]), .bit_cnt_o(bit_cnt[1]),
    .frame_valid_o(frame_valid[1]), .frame_ready_i(frame_ready[1]),
    .busy_o(busy[1]), .frame_cnt_o(frame_cnt[1]));

  serial_buff_ctrl #(.CLKDIV(4), .CONT(1'b0)) u_d4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]), .abort_i(abort), .din_i(din),
    .buf_clr_o(buf_clr[2]), .shift_en_o(shift_en[2]), .bit_cnt_o(bit_cnt[2]),
    .frame_valid_o(frame_valid[2]), .frame_ready_i(frame_ready[2]),
    .busy_o(busy[2]), .frame_cnt_o(frame_cnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Models the serial_buff shift register from the selected instance's shift_en.
  task automatic tick();
    int div;
    div = (sel == 2) ? 4 : 1;
    if (shift_en[sel] === 1'b1) begin
      cap = {cap[126:0], din};
      if (last_sh >= 0 && (cyc - last_sh) != div) bad_gap++;
      if (first_sh < 0) first_sh = cyc;
      last_sh = cyc;
      nshift++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_mon();
    nshift = 0; first_sh = -1; last_sh = -1; bad_gap = 0; cap = '0;
  endtask

  task automatic send_bit(input logic b, input int hold);
    din = b;
    repeat (hold) tick();
  endtask

  task automatic send_word8(input logic [7:0] w, input int hold);
    for (int i = 7; i >= 0; i--) send_bit(w[i], hold);
  endtask

  task automatic send_data(input int n, input int hold);
    for (int i = 0; i < n; i++) send_bit(data[127-i], hold);
  endtask

  task automatic start_pulse(input int s);
    start[s] = 1'b1;
    tick();
    start[s] = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; abort = 1'b0; din = 1'b0;
    for (int i = 0; i < 3; i++) begin start[i] = 1'b1; frame_ready[i] = 1'b0; end
    reset_mon();

    // Reset held with start asserted and noisy din
    repeat (5) begin din = 1'($urandom); tick(); end
    chk("rst_busy0", 128'(busy[0]), 128'd0);
    chk("rst_busy1", 128'(busy[1]), 128'd0);
    chk("rst_busy2", 128'(busy[2]), 128'd0);
    chk("rst_bufclr", 128'(buf_clr[0]), 128'd0);
    chk("rst_shen", 128'(shift_en[0]), 128'd0);
    chk("rst_bitcnt", 128'(bit_cnt[0]), 128'd0);
    chk("rst_fvalid", 128'(frame_valid[0]), 128'd0);
    chk("rst_fcnt", 128'(frame_cnt[0]), 128'd0);
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    din = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle_after_rst", 128'(busy[0]), 128'd0);

    // Nominal frame, CLKDIV=1, CONT=0
    sel = 0;
    start_pulse(0);
    chk("start_busy", 128'(busy[0]), 128'd1);
    chk("start_bufclr", 128'(buf_clr[0]), 128'd1);
    tick();
    chk("bufclr_one_cycle", 128'(buf_clr[0]), 128'd0);
    reset_mon();
    send_word8(8'hA5, 1);
    chk("nom_no_shift_in_sync", 128'(nshift), 128'd0);
    chk("nom_shen_after_sync", 128'(shift_en[0]), 128'd1);
    data = {$urandom, $urandom, $urandom, $urandom};
    send_data(128, 1);
    chk("nom_nshift", 128'(nshift), 128'd128);
    chk("nom_consecutive", 128'(bad_gap), 128'd0);
    chk("nom_dout", cap, data);
    chk("nom_fvalid", 128'(frame_valid[0]), 128'd1);
    chk("nom_bitcnt", 128'(bit_cnt[0]), 128'd128);
    chk("nom_shen_hold", 128'(shift_en[0]), 128'd0);
    frame_ready[0] = 1'b1;
    tick();
    frame_ready[0] = 1'b0;
    chk("nom_fvalid_drop", 128'(frame_valid[0]), 128'd0);
    chk("nom_fcnt", 128'(frame_cnt[0]), 128'd1);
    chk("nom_idle", 128'(busy[0]), 128'd0);

    // Near-miss 0xA4 then true 0xA5, then abort at bit 60
    start_pulse(0);
    reset_mon();
    send_word8(8'hA4, 1);
    chk("hunt_a4_no_shift", 128'(nshift), 128'd0);
    send_word8(8'hA5, 1);
    chk("hunt_a5_no_early", 128'(nshift), 128'd0);
    chk("hunt_a5_capture", 128'(shift_en[0]), 128'd1);
    data = {$urandom, $urandom, $urandom, $urandom};
    send_data(60, 1);
    chk("abort_bitcnt60", 128'(bit_cnt[0]), 128'd60);
    do_abort();
    chk("abort_idle", 128'(busy[0]), 128'd0);
    chk("abort_bitcnt", 128'(bit_cnt[0]), 128'd0);
    chk("abort_shen", 128'(shift_en[0]), 128'd0);
    chk("abort_fcnt", 128'(frame_cnt[0]), 128'd1);
    chk("abort_fvalid", 128'(frame_valid[0]), 128'd0);

    // Sync word at an odd offset behind a partial prefix
    start_pulse(0);
    reset_mon();
    send_bit(1'b1, 1); send_bit(1'b0, 1); send_bit(1'b1, 1);
    send_word8(8'hA5, 1);
    chk("odd_no_early", 128'(nshift), 128'd0);
    chk("odd_capture", 128'(shift_en[0]), 128'd1);
    tick();
    chk("odd_bitcnt1", 128'(bit_cnt[0]), 128'd1);
    do_abort();

    // Backpressure with CONT=1
    sel = 1;
    start_pulse(1);
    reset_mon();
    send_word8(8'hA5, 1);
    data = {$urandom, $urandom, $urandom, $urandom};
    send_data(128, 1);
    chk("bp_fvalid", 128'(frame_valid[1]), 128'd1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      din = 1'($urandom);
      tick();
      if (frame_valid[1] !== 1'b1 || shift_en[1] !== 1'b0) bad++;
    end
    chk("bp_stall_stable", 128'(bad), 128'd0);
    chk("bp_nshift", 128'(nshift), 128'd128);
    chk("bp_dout", cap, data);
    chk("bp_fcnt_before", 128'(frame_cnt[1]), 128'd0);
    frame_ready[1] = 1'b1;
    tick();
    frame_ready[1] = 1'b0;
    chk("bp_fvalid_drop", 128'(frame_valid[1]), 128'd0);
    chk("bp_fcnt", 128'(frame_cnt[1]), 128'd1);
    chk("bp_bufclr", 128'(buf_clr[1]), 128'd1);
    chk("bp_rehunt_busy", 128'(busy[1]), 128'd1);
    chk("bp_bitcnt0", 128'(bit_cnt[1]), 128'd0);
    tick();
    chk("bp_bufclr_pulse", 128'(buf_clr[1]), 128'd0);
    reset_mon();
    send_word8(8'hA5, 1);
    chk("bp_rehunt_capture", 128'(shift_en[1]), 128'd1);
    do_abort();

    // CLKDIV=4 full frame timing
    sel = 2;
    start_pulse(2);
    h0 = cyc;
    reset_mon();
    send_word8(8'hA5, 4);
    chk("div4_no_shift_in_sync", 128'(nshift), 128'd0);
    data = {$urandom, $urandom, $urandom, $urandom};
    send_data(128, 4);
    chk("div4_first_shift", 128'(first_sh - h0), 128'd35);
    chk("div4_last_shift", 128'(last_sh - h0), 128'd543);
    chk("div4_nshift", 128'(nshift), 128'd128);
    chk("div4_gap4", 128'(bad_gap), 128'd0);
    chk("div4_dout", cap, data);
    chk("div4_fvalid", 128'(frame_valid[2]), 128'd1);
    frame_ready[2] = 1'b1;
    tick();
    frame_ready[2] = 1'b0;
    chk("div4_fcnt", 128'(frame_cnt[2]), 128'd1);
    chk("div4_idle", 128'(busy[2]), 128'd0);

    // Asynchronous reset in the middle of a frame
    sel = 0;
    start_pulse(0);
    reset_mon();
    send_word8(8'hA5, 1);
    send_data(60, 1);
    chk("rstmid_bitcnt60", 128'(bit_cnt[0]), 128'd60);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 128'(busy[0]), 128'd0);
    chk("rstmid_bitcnt", 128'(bit_cnt[0]), 128'd0);
    chk("rstmid_shen", 128'(shift_en[0]), 128'd0);
    chk("rstmid_fcnt", 128'(frame_cnt[0]), 128'd0);
    chk("rstmid_fvalid", 128'(frame_valid[0]), 128'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
